// File: rtl/irom_loader.sv
// irom_loader: boot loader that fills instruction memory from a framed byte stream.
//
// Frame: MAGIC, CNT_LO, CNT_HI, 4*N data bytes (little-endian words), CSUM (XOR of data).
// The core is held in reset (cpu_rst_n low) until a frame completes with a good checksum.
//
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   s_valid/s_data  input byte stream; s_ready accepts (always 1 once out of reset)
//   imem_we         one-cycle write strobe per assembled word
//   imem_addr       word address of the write (holds last value when idle)
//   imem_wdata      assembled 32-bit word (holds last value when idle)
//   cpu_rst_n       core reset, high only after a good load
//   load_busy       frame in progress
//   load_done       last frame loaded with good checksum
//   load_err        last frame failed (oversize count or bad checksum)
//
// state  | meaning
// IDLE   | waiting for MAGIC, other bytes dropped
// CNT_LO | expecting low byte of word count
// CNT_HI | expecting high byte of word count
// DATA   | collecting data bytes, writing each completed word
// CSUM   | expecting checksum byte
// DONE   | good load, core released; MAGIC restarts
// ERR    | failed load, core held; MAGIC restarts
module irom_loader #(
   parameter int          ADDR_W = 14,
   parameter int          DEPTH  = 16384,
   parameter logic [7:0]  MAGIC  = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst_n,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CNT_LO = 3'd1,
      CNT_HI = 3'd2,
      DATA   = 3'd3,
      CSUM   = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

   state_t          state;
   logic [7:0]      cnt_lo;
   logic [ADDR_W:0] word_total;
   // One extra bit so a count equal to DEPTH terminates without wrapping.
   logic [ADDR_W:0] word_cnt;
   logic [1:0]      byte_cnt;
   logic [23:0]     word_buf;
   logic [7:0]      csum;

   logic            accept;
   logic [15:0]     n_words;
   logic [ADDR_W:0] word_cnt_inc;

   assign accept       = s_valid && s_ready;
   assign n_words      = {s_data, cnt_lo};
   assign word_cnt_inc = word_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         s_ready    <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_rst_n  <= 1'b0;
         load_busy  <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         cnt_lo     <= '0;
         word_total <= '0;
         word_cnt   <= '0;
         byte_cnt   <= '0;
         word_buf   <= '0;
         csum       <= '0;
      end else begin
         s_ready <= 1'b1;
         imem_we <= 1'b0;
         if (accept) begin
            case (state)
               IDLE, DONE, ERR: begin
                  if (s_data == MAGIC) begin
                     state     <= CNT_LO;
                     cpu_rst_n <= 1'b0;
                     load_busy <= 1'b1;
                     load_done <= 1'b0;
                     load_err  <= 1'b0;
                  end
               end
               CNT_LO: begin
                  cnt_lo <= s_data;
                  state  <= CNT_HI;
               end
               CNT_HI: begin
                  word_cnt <= '0;
                  byte_cnt <= '0;
                  csum     <= '0;
                  if (n_words == 16'd0) begin
                     state <= CSUM;
                  end else if (32'(n_words) > DEPTH) begin
                     state     <= ERR;
                     load_err  <= 1'b1;
                     load_busy <= 1'b0;
                     cpu_rst_n <= 1'b0;
                  end else begin
                     // Count fits in ADDR_W+1 bits once it is known to be <= DEPTH.
                     word_total <= n_words[ADDR_W:0];
                     state      <= DATA;
                  end
               end
               DATA: begin
                  csum     <= csum ^ s_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  word_buf <= {s_data, word_buf[23:8]};
                  if (byte_cnt == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= word_cnt[ADDR_W-1:0];
                     imem_wdata <= {s_data, word_buf};
                     word_cnt   <= word_cnt_inc;
                     if (word_cnt_inc == word_total) begin
                        state <= CSUM;
                     end
                  end
               end
               CSUM: begin
                  load_busy <= 1'b0;
                  if (s_data == csum) begin
                     state     <= DONE;
                     load_done <= 1'b1;
                     cpu_rst_n <= 1'b1;
                  end else begin
                     state     <= ERR;
                     load_err  <= 1'b1;
                     cpu_rst_n <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_irom_loader.sv
module tb_irom_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        imem_we;
   logic [13:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst_n;
   logic        load_busy;
   logic        load_done;
   logic        load_err;

   int n_checks = 0;
   int n_fails  = 0;

   int          wr_n = 0;
   logic [13:0] wr_addr [16];
   logic [31:0] wr_data [16];

   logic [7:0] good_frame [12] = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50,
                                   8'h00, 8'h13, 8'h01, 8'h30, 8'h00, 8'hE1};

   always #5 clk = ~clk;

   irom_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .load_busy  (load_busy),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   // Log every write strobe, sampled mid-cycle.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (wr_n < 16) begin
            wr_addr[wr_n] = imem_addr;
            wr_data[wr_n] = imem_wdata;
         end
         wr_n = wr_n + 1;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (s_ready !== 1'b1 && n < 50);
      #1 s_valid = 1'b0;
      if (s_ready !== 1'b1) begin
         n_checks++; n_fails++;
         $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
      end
   endtask

   task automatic send_frame(input logic [7:0] last, input int max_gap);
      for (int i = 0; i < 12; i++)
         send_byte((i == 11) ? last : good_frame[i], $urandom_range(0, max_gap));
   endtask

   task automatic check_good(input string tag);
      repeat (2) @(negedge clk);
      n_checks++;
      if (wr_n !== 2) begin n_fails++; $display("FAIL %s_wr_count: got %0d required 2", tag, wr_n); end
      n_checks++;
      if (wr_addr[0] !== 14'd0 || wr_data[0] !== 32'h00500093) begin
         n_fails++; $display("FAIL %s_word0: got %0d/%h required 0/00500093", tag, wr_addr[0], wr_data[0]);
      end
      n_checks++;
      if (wr_addr[1] !== 14'd1 || wr_data[1] !== 32'h00300113) begin
         n_fails++; $display("FAIL %s_word1: got %0d/%h required 1/00300113", tag, wr_addr[1], wr_data[1]);
      end
      n_checks++;
      if ({load_done, cpu_rst_n, load_err, load_busy} !== 4'b1100) begin
         n_fails++;
         $display("FAIL %s_flags: got done,rst,err,busy=%b required 1100", tag,
                  {load_done, cpu_rst_n, load_err, load_busy});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      n_checks++;
      if ({s_ready, imem_we, cpu_rst_n, load_busy, load_done, load_err} !== 6'b0 ||
          imem_addr !== 14'd0 || imem_wdata !== 32'd0) begin
         n_fails++;
         $display("FAIL %s: got rdy,we,rst,busy,done,err=%b addr=%0d wdata=%h required all 0", tag,
                  {s_ready, imem_we, cpu_rst_n, load_busy, load_done, load_err}, imem_addr, imem_wdata);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_values");
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (s_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin
         n_fails++; $display("FAIL ready_after_reset: got rdy=%b rst=%b required 1/0", s_ready, cpu_rst_n);
      end
   endtask

   task automatic test_good_load;
      wr_n = 0;
      send_byte(8'hA5, 0);
      @(negedge clk);
      n_checks++;
      if (load_busy !== 1'b1 || cpu_rst_n !== 1'b0) begin
         n_fails++; $display("FAIL busy_after_magic: got busy=%b rst=%b required 1/0", load_busy, cpu_rst_n);
      end
      for (int i = 1; i < 12; i++) send_byte(good_frame[i], 0);
      check_good("good");
   endtask

   task automatic test_bad_csum;
      wr_n = 0;
      send_frame(8'hE0, 0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (wr_n !== 2) begin n_fails++; $display("FAIL badcs_wr_count: got %0d required 2", wr_n); end
      n_checks++;
      if ({load_done, cpu_rst_n, load_err, load_busy} !== 4'b0010) begin
         n_fails++;
         $display("FAIL badcs_flags: got done,rst,err,busy=%b required 0010",
                  {load_done, cpu_rst_n, load_err, load_busy});
      end
   endtask

   task automatic test_oversize;
      wr_n = 0;
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h40, 0);
      @(negedge clk);
      n_checks++;
      if (load_err !== 1'b1 || load_busy !== 1'b0) begin
         n_fails++; $display("FAIL oversize_err: got err=%b busy=%b required 1/0", load_err, load_busy);
      end
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (wr_n !== 0 || load_err !== 1'b1 || load_busy !== 1'b0) begin
         n_fails++; $display("FAIL oversize_discard: got writes=%0d err=%b busy=%b required 0/1/0", wr_n, load_err, load_busy);
      end
   endtask

   task automatic test_max_count;
      // N == DEPTH is legal: enters DATA rather than ERR.
      send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h40, 0);
      @(negedge clk);
      n_checks++;
      if (load_err !== 1'b0 || load_busy !== 1'b1) begin
         n_fails++; $display("FAIL max_count: got err=%b busy=%b required 0/1", load_err, load_busy);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_bubbles;
      wr_n = 0;
      send_byte(8'h00, 2); send_byte(8'hFF, 0); send_byte(8'h5A, 3);
      send_frame(8'hE1, 5);
      check_good("bubbles");
   endtask

   task automatic test_reset_mid;
      wr_n = 0;
      for (int i = 0; i < 9; i++) send_byte(good_frame[i], 0);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("midreset_values");
      n_checks++;
      if (wr_n !== 1 || wr_data[0] !== 32'h00500093) begin
         n_fails++; $display("FAIL midreset_writes: got %0d/%h required 1/00500093", wr_n, wr_data[0]);
      end
      rst_n = 1'b1;
      wr_n = 0;
      send_frame(8'hE1, 0);
      check_good("after_midreset");
   endtask

   task automatic test_reload;
      wr_n = 0;
      send_byte(8'hA5, 0);
      @(negedge clk);
      n_checks++;
      if ({load_done, cpu_rst_n, load_busy} !== 3'b001) begin
         n_fails++; $display("FAIL reload_start: got done,rst,busy=%b required 001", {load_done, cpu_rst_n, load_busy});
      end
      send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      repeat (2) @(negedge clk);
      n_checks++;
      if ({load_done, cpu_rst_n, load_err, load_busy} !== 4'b1100 || wr_n !== 0) begin
         n_fails++;
         $display("FAIL reload_empty: got done,rst,err,busy=%b writes=%0d required 1100/0",
                  {load_done, cpu_rst_n, load_err, load_busy}, wr_n);
      end
   endtask

   initial begin
      test_reset;
      test_good_load;
      test_bad_csum;
      test_oversize;
      test_max_count;
      test_bubbles;
      test_reset_mid;
      test_reload;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
